ex_mem_register: RTL and testbench

EX/MEM pipeline stage of the RISC-V datapath, sitting directly downstream of the ALU. Each cycle it captures the ALU result, zero flag, branch target, store data and control bits. It resolves BEQ/BNE into a one-shot `pc_src` pulse and presents an aligned, byte-enabled request to data memory. It supports stall (hold) and flush (bubble) from the hazard unit and flags misaligned accesses.

---
 rtl/ex_mem_register.sv | 161 ++++++++++++++++
 tb/tb_ex_mem_register.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register: captures ALU/control state, resolves BEQ/BNE and drives the data-memory request.
// Optional macro EXMEM_FWD_EN adds the fwd_valid/fwd_rd/fwd_data forwarding outputs.
module ex_mem_register (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  input  logic [31:0] branch_target,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  funct3,
  input  logic        ctl_mem_read,
  input  logic        ctl_mem_write,
  input  logic        ctl_reg_write,
  input  logic        ctl_mem_to_reg,
  input  logic        ctl_branch,
  output logic        out_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byte_en,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic [4:0]  rd_o,
  output logic [31:0] branch_target_o,
  output logic        pc_src,
  output logic        misaligned
`ifdef EXMEM_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data
`endif
);

  logic        valid_q, valid_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] target_q, target_d;
  logic [31:0] sdata_q, sdata_d;
  logic [4:0]  rd_q, rd_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic        taken_q, taken_d;
  logic        fired_q, fired_d;

  logic        capture;
  logic        cap_valid;
  logic [1:0]  a;

  assign capture   = flush | ~stall;
  assign cap_valid = in_valid & ~flush;
  assign a         = addr_q[1:0];

  always_comb begin
    valid_d      = valid_q;
    addr_d       = addr_q;
    target_d     = target_q;
    sdata_d      = sdata_q;
    rd_d         = rd_q;
    funct3_d     = funct3_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    taken_d      = taken_q;
    fired_d      = fired_q | pc_src;
    if (capture) begin
      // Bubbles keep the datapath fields but drop every control bit.
      valid_d      = cap_valid;
      addr_d       = alu_result;
      target_d     = branch_target;
      sdata_d      = store_data;
      rd_d         = rd_in;
      funct3_d     = funct3;
      mem_read_d   = cap_valid & ctl_mem_read;
      mem_write_d  = cap_valid & ctl_mem_write;
      reg_write_d  = cap_valid & ctl_reg_write;
      mem_to_reg_d = cap_valid & ctl_mem_to_reg;
      taken_d      = cap_valid & ctl_branch &
                     (((funct3 == 3'b000) & alu_zero) | ((funct3 == 3'b001) & ~alu_zero));
      fired_d      = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= 1'b0;
      addr_q       <= '0;
      target_q     <= '0;
      sdata_q      <= '0;
      rd_q         <= '0;
      funct3_q     <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      taken_q      <= 1'b0;
      fired_q      <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      target_q     <= target_d;
      sdata_q      <= sdata_d;
      rd_q         <= rd_d;
      funct3_q     <= funct3_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      taken_q      <= taken_d;
      fired_q      <= fired_d;
    end
  end

  // Size comes from funct3[1:0] so unsigned loads alias onto their signed counterparts.
  assign misaligned = valid_q & (mem_read_q | mem_write_q) &
                      (((funct3_q[1:0] == 2'b01) & a[0]) |
                       ((funct3_q[1:0] == 2'b10) & (a != 2'b00)));

  assign out_valid       = valid_q;
  assign mem_addr        = addr_q;
  assign branch_target_o = target_q;
  assign rd_o            = rd_q;
  assign reg_write_o     = reg_write_q;
  assign mem_to_reg_o    = mem_to_reg_q;
  assign mem_read_o      = valid_q & mem_read_q & ~misaligned;
  assign mem_write_o     = valid_q & mem_write_q & ~misaligned;
  assign pc_src          = valid_q & taken_q & ~fired_q;

  always_comb begin
    mem_byte_en = 4'b0000;
    mem_wdata   = sdata_q;
    case (funct3_q)
      3'b000: begin
        mem_byte_en = 4'b0001 << a;
        mem_wdata   = {4{sdata_q[7:0]}};
      end
      3'b001: begin
        mem_byte_en = a[1] ? 4'b1100 : 4'b0011;
        mem_wdata   = {2{sdata_q[15:0]}};
      end
      3'b010:  mem_byte_en = 4'b1111;
      default: mem_byte_en = 4'b0000;
    endcase
    if (!mem_write_o) mem_byte_en = 4'b0000;
  end

`ifdef EXMEM_FWD_EN
  assign fwd_valid = valid_q & reg_write_q & ~mem_to_reg_q & (rd_q != 5'd0);
  assign fwd_rd    = rd_q;
  assign fwd_data  = addr_q;
`endif

endmodule

// File: tb/tb_ex_mem_register.sv
// Self-checking bench for ex_mem_register: vector table, hand sequences, randomized run vs. a reference model.
module tb_ex_mem_register;

  logic        clock = 1'b0;
  logic        reset_n, in_valid, stall, flush, alu_zero;
  logic [31:0] alu_result, branch_target, store_data;
  logic [4:0]  rd_in;
  logic [2:0]  funct3;
  logic        ctl_mem_read, ctl_mem_write, ctl_reg_write, ctl_mem_to_reg, ctl_branch;
  logic        out_valid, mem_read_o, mem_write_o, reg_write_o, mem_to_reg_o, pc_src, misaligned;
  logic [31:0] mem_addr, mem_wdata, branch_target_o;
  logic [3:0]  mem_byte_en;
  logic [4:0]  rd_o;
`ifdef EXMEM_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  always #5 clock = ~clock;

  ex_mem_register dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_result(alu_result), .alu_zero(alu_zero), .branch_target(branch_target),
    .store_data(store_data), .rd_in(rd_in), .funct3(funct3),
    .ctl_mem_read(ctl_mem_read), .ctl_mem_write(ctl_mem_write), .ctl_reg_write(ctl_reg_write),
    .ctl_mem_to_reg(ctl_mem_to_reg), .ctl_branch(ctl_branch),
    .out_valid(out_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .reg_write_o(reg_write_o),
    .mem_to_reg_o(mem_to_reg_o), .rd_o(rd_o), .branch_target_o(branch_target_o),
    .pc_src(pc_src), .misaligned(misaligned)
`ifdef EXMEM_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: the last captured instruction plus "is this its first cycle in the stage".
  logic        m_valid, m_mr, m_mw, m_rw, m_m2r, m_br, m_zero, m_first;
  logic [31:0] m_alu, m_tgt, m_sd;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;

  task automatic model_reset();
    m_valid = 0; m_mr = 0; m_mw = 0; m_rw = 0; m_m2r = 0; m_br = 0; m_zero = 0; m_first = 0;
    m_alu = 0; m_tgt = 0; m_sd = 0; m_rd = 0; m_f3 = 0;
  endtask

  task automatic model_edge();
    if (flush || !stall) begin
      m_valid = in_valid && !flush;
      m_alu = alu_result; m_tgt = branch_target; m_sd = store_data; m_rd = rd_in;
      m_f3 = funct3; m_zero = alu_zero;
      m_mr = m_valid && ctl_mem_read;  m_mw  = m_valid && ctl_mem_write;
      m_rw = m_valid && ctl_reg_write; m_m2r = m_valid && ctl_mem_to_reg;
      m_br = m_valid && ctl_branch;
      m_first = 1;
    end else begin
      m_first = 0;
    end
  endtask

  task automatic compare_model();
    int          size;
    logic        mis, e_rd, e_wr, taken;
    logic [3:0]  be;
    logic [31:0] wd;
    size  = int'(m_f3[1:0]);
    mis   = m_valid && (m_mr || m_mw) &&
            ((size == 1 && m_alu % 2 != 0) || (size == 2 && m_alu % 4 != 0));
    e_rd  = m_valid && m_mr && !mis;
    e_wr  = m_valid && m_mw && !mis;
    taken = m_br && ((m_f3 == 0 && m_zero) || (m_f3 == 1 && !m_zero));
    be = 4'd0;
    if (e_wr) begin
      if (m_f3 == 0) be = 4'(1 << (m_alu % 4));
      else if (m_f3 == 1) be = (m_alu % 4 >= 2) ? 4'd12 : 4'd3;
      else if (m_f3 == 2) be = 4'd15;
    end
    if (m_f3 == 0) wd = (m_sd & 32'hFF) * 32'h01010101;
    else if (m_f3 == 1) wd = (m_sd & 32'hFFFF) * 32'h00010001;
    else wd = m_sd;
    chk("out_valid",       32'(out_valid),       32'(m_valid));
    chk("mem_addr",        mem_addr,             m_alu);
    chk("mem_wdata",       mem_wdata,            wd);
    chk("mem_byte_en",     32'(mem_byte_en),     32'(be));
    chk("mem_read_o",      32'(mem_read_o),      32'(e_rd));
    chk("mem_write_o",     32'(mem_write_o),     32'(e_wr));
    chk("reg_write_o",     32'(reg_write_o),     32'(m_rw));
    chk("mem_to_reg_o",    32'(mem_to_reg_o),    32'(m_m2r));
    chk("rd_o",            32'(rd_o),            32'(m_rd));
    chk("branch_target_o", branch_target_o,      m_tgt);
    chk("pc_src",          32'(pc_src),          32'(m_valid && taken && m_first));
    chk("misaligned",      32'(misaligned),      32'(mis));
`ifdef EXMEM_FWD_EN
    chk("fwd_valid", 32'(fwd_valid), 32'(m_valid && m_rw && !m_m2r && m_rd != 0));
    chk("fwd_rd",    32'(fwd_rd),    32'(m_rd));
    chk("fwd_data",  fwd_data,       m_alu);
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset_n) model_edge();
    @(negedge clock);
    compare_model();
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [31:0] sd, input logic [2:0] f3,
                        input logic mr, input logic mw, input logic rw, input logic br,
                        input logic zero);
    in_valid = 1; alu_result = alu; store_data = sd; funct3 = f3;
    ctl_mem_read = mr; ctl_mem_write = mw; ctl_reg_write = rw; ctl_mem_to_reg = mr;
    ctl_branch = br; alu_zero = zero;
  endtask

  typedef struct {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [2:0]  f3;
    logic        mr, mw, br, zero;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_rdo, exp_wro, exp_mis, exp_pc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{32'h1003, 32'h000000AB, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 32'hABABABAB, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{32'h1002, 32'h11223344, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h11223344, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{32'h1002, 32'hCDEF1234, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1100, 32'h12341234, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{32'h1001, 32'hCDEF1234, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h12341234, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{32'h2000, 32'hDEADBEEF, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{32'h1003, 32'h00000000, 3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{32'h1004, 32'h00000000, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'h0000, 32'h00000000, 3'b001, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{32'h0000, 32'h00000000, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{32'h0000, 32'h00000000, 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h1001, 32'h0000005A, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 32'h5A5A5A5A, 1'b0, 1'b1, 1'b0, 1'b0};

    reset_n = 0; in_valid = 0; stall = 0; flush = 0; alu_zero = 0;
    alu_result = 0; branch_target = 0; store_data = 0; rd_in = 0; funct3 = 0;
    ctl_mem_read = 0; ctl_mem_write = 0; ctl_reg_write = 0; ctl_mem_to_reg = 0; ctl_branch = 0;
    model_reset();
    @(negedge clock); @(negedge clock);
    compare_model();
    reset_n = 1;

    // Table-driven single-instruction vectors.
    for (int i = 0; i < 11; i++) begin
      set_op(vecs[i].alu, vecs[i].sd, vecs[i].f3, vecs[i].mr, vecs[i].mw, 1'b0, vecs[i].br, vecs[i].zero);
      rd_in = 5'(i + 1); branch_target = 32'h4000 + 32'(i);
      tick();
      $display("vec %0d: be=%b wdata=%08h rd=%b wr=%b mis=%b pc=%b", i, mem_byte_en, mem_wdata,
               mem_read_o, mem_write_o, misaligned, pc_src);
      chk("vec_byte_en",   32'(mem_byte_en), 32'(vecs[i].exp_be));
      chk("vec_wdata",     mem_wdata,        vecs[i].exp_wdata);
      chk("vec_read",      32'(mem_read_o),  32'(vecs[i].exp_rdo));
      chk("vec_write",     32'(mem_write_o), 32'(vecs[i].exp_wro));
      chk("vec_misalign",  32'(misaligned),  32'(vecs[i].exp_mis));
      chk("vec_pc_src",    32'(pc_src),      32'(vecs[i].exp_pc));
    end

    // BEQ taken then three stall cycles: one pulse, target held.
    set_op(32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    branch_target = 32'h8000_0040;
    tick();
    chk("beq_first_pulse", 32'(pc_src), 32'd1);
    stall = 1; branch_target = 32'h1234_5678; alu_zero = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      $display("stall cycle %0d: pc_src=%b target=%08h", k, pc_src, branch_target_o);
      chk("beq_stall_pc_src", 32'(pc_src), 32'd0);
      chk("beq_stall_target", branch_target_o, 32'h8000_0040);
    end
    // Back-to-back taken branches each pulse once.
    stall = 0; alu_zero = 1; branch_target = 32'h8000_0080;
    tick();
    chk("b2b_pulse1", 32'(pc_src), 32'd1);
    tick();
    chk("b2b_pulse2", 32'(pc_src), 32'd1);

    // Stall and flush together with a valid load: bubble wins.
    set_op(32'h1000, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    stall = 1; flush = 1;
    tick();
    chk("flush_stall_valid", 32'(out_valid), 32'd0);
    chk("flush_stall_read",  32'(mem_read_o), 32'd0);
    stall = 0; flush = 0;

`ifdef EXMEM_FWD_EN
    set_op(32'h55, 32'h0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); rd_in = 5;
    tick();
    chk("fwd_valid_rd5", 32'(fwd_valid), 32'd1);
    chk("fwd_rd_rd5",    32'(fwd_rd),    32'd5);
    rd_in = 0;
    tick();
    chk("fwd_valid_rd0", 32'(fwd_valid), 32'd0);
`endif

    // Reset mid-stall discards the held store immediately.
    set_op(32'h2004, 32'hCAFEF00D, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); rd_in = 7;
    tick();
    chk("pre_reset_write", 32'(mem_write_o), 32'd1);
    stall = 1;
    tick();
    chk("stall_write_held", 32'(mem_write_o), 32'd1);
    reset_n = 0;
    #1;
    model_reset();
    chk("rst_out_valid", 32'(out_valid),   32'd0);
    chk("rst_write",     32'(mem_write_o), 32'd0);
    chk("rst_byte_en",   32'(mem_byte_en), 32'd0);
    chk("rst_addr",      mem_addr,         32'd0);
    chk("rst_rd",        32'(rd_o),        32'd0);
    compare_model();
    @(negedge clock);
    reset_n = 1; stall = 0;
    tick();
    chk("post_reset_capture", 32'(out_valid), 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r;
      r = $urandom;
      in_valid = r[0]; stall = (r[3:1] < 3'd2); flush = (r[6:4] == 3'd0);
      alu_zero = r[7]; funct3 = r[10:8]; rd_in = r[15:11];
      ctl_mem_read = r[16]; ctl_mem_write = r[17]; ctl_reg_write = r[18];
      ctl_mem_to_reg = r[19]; ctl_branch = r[20];
      alu_result = $urandom; store_data = $urandom; branch_target = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
